// File: rtl/qam16_pkg.sv
// Shared 16QAM definitions: level constants, Gray level map and FSM state encoding.
// The PREAMBLE state only exists when QAM16_PREAMBLE_EN is defined.
package qam16_pkg;

  localparam int AMP_DEF = 32;

  localparam logic [7:0] LVL_P1 = 8'(AMP_DEF);
  localparam logic [7:0] LVL_P3 = 8'(3 * AMP_DEF);
  localparam logic [7:0] LVL_N1 = 8'(-AMP_DEF);
  localparam logic [7:0] LVL_N3 = 8'(-3 * AMP_DEF);

`ifdef QAM16_PREAMBLE_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_PREAMBLE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;
`endif

  // Gray order along the axis: 00 -> -3u, 01 -> -u, 11 -> +u, 10 -> +3u (two's complement).
  function automatic logic [7:0] gray_level(input logic [1:0] bits, input logic [7:0] unit);
    logic [7:0] unit3;
    logic [7:0] level;
    unit3 = unit + unit + unit;
    case (bits)
      2'b00:   level = 8'd0 - unit3;
      2'b01:   level = 8'd0 - unit;
      2'b11:   level = unit;
      2'b10:   level = unit3;
      default: level = 8'd0;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/qam16_sym_fifo.sv
// Synchronous nibble FIFO (DEPTH x 4) with full/empty flags and a fall-through read port.
// Writes are refused while full and reads while empty; pointers wrap modulo DEPTH.
module qam16_sym_fifo
  import qam16_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic       rd_en,
  output logic [3:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s;
  logic          pop_s;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == {(AW+1){1'b0}});
  assign push_s  = wr_en && !full;
  assign pop_s   = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; reset discards all buffered nibbles at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/qam16_mapper.sv
// Hard-mapping 16QAM modulator: buffers nibbles and emits one Gray-coded I/Q symbol per tick.
// Optional preamble (alternating +-3A symbols before data) is built with QAM16_PREAMBLE_EN.
module qam16_mapper
  import qam16_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int SYM_DIV      = 4,
  parameter int AMP          = 32,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              enable,
  input  logic [3:0]        data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic signed [7:0] I_out,
  output logic signed [7:0] Q_out,
  output logic              sym_valid,
  output logic              underrun
);

  if (SYM_DIV < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      3 * AMP > 127 || PREAMBLE_LEN < 1) begin : g_param_check
    $error("qam16_mapper: illegal parameter combination");
  end

  localparam int         CW       = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYM_DIV - 1);
  localparam logic [7:0] UNIT     = 8'(AMP);

  state_t        state_r;
  logic [CW-1:0] div_cnt_r;
  logic          tick_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [3:0]    fifo_data_s;

`ifdef QAM16_PREAMBLE_EN
  localparam int PW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_LEN - 1);
  logic [PW-1:0] pre_cnt_r;
`endif

  qam16_sym_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (sclk),
    .rst     (rst),
    .wr_en   (data_valid),
    .wr_data (data_in),
    .rd_en   (pop_s),
    .rd_data (fifo_data_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Ready depends only on full, so a same-cycle pop never opens a slot for a write.
  assign data_ready = !full_s;
  assign tick_s     = enable && (state_r != ST_IDLE) && (div_cnt_r == CNT_LAST);
  assign pop_s      = tick_s && (state_r == ST_RUN) && !empty_s;

  // Symbol divider: runs only while transmitting, held at zero otherwise.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {CW{1'b0}};
    end else if (!enable || state_r == ST_IDLE || tick_s) begin
      div_cnt_r <= {CW{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + CW'(1'b1);
    end
  end

  // Transmit FSM with registered symbol, strobe and underrun outputs.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      I_out     <= 8'sd0;
      Q_out     <= 8'sd0;
      sym_valid <= 1'b0;
      underrun  <= 1'b0;
`ifdef QAM16_PREAMBLE_EN
      pre_cnt_r <= {PW{1'b0}};
`endif
    end else begin
      sym_valid <= 1'b0;
      underrun  <= 1'b0;
      if (!enable) begin
        state_r <= ST_IDLE;
        I_out   <= 8'sd0;
        Q_out   <= 8'sd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            I_out <= 8'sd0;
            Q_out <= 8'sd0;
            if (!empty_s) begin
`ifdef QAM16_PREAMBLE_EN
              state_r   <= ST_PREAMBLE;
              pre_cnt_r <= {PW{1'b0}};
`else
              state_r   <= ST_RUN;
`endif
            end
          end
          ST_RUN: begin
            if (tick_s) begin
              if (!empty_s) begin
                I_out     <= gray_level(fifo_data_s[3:2], UNIT);
                Q_out     <= gray_level(fifo_data_s[1:0], UNIT);
                sym_valid <= 1'b1;
              end else begin
                underrun <= 1'b1;
                I_out    <= 8'sd0;
                Q_out    <= 8'sd0;
                state_r  <= ST_IDLE;
              end
            end
          end
`ifdef QAM16_PREAMBLE_EN
          ST_PREAMBLE: begin
            if (tick_s) begin
              // Even-numbered preamble symbols sit at (+3A,+3A), odd ones at (-3A,-3A).
              I_out     <= gray_level(pre_cnt_r[0] ? 2'b00 : 2'b10, UNIT);
              Q_out     <= gray_level(pre_cnt_r[0] ? 2'b00 : 2'b10, UNIT);
              sym_valid <= 1'b1;
              if (pre_cnt_r == PRE_LAST) begin
                pre_cnt_r <= {PW{1'b0}};
                state_r   <= ST_RUN;
              end else begin
                pre_cnt_r <= pre_cnt_r + PW'(1'b1);
              end
            end
          end
`endif
          default: begin
            state_r <= ST_IDLE;
            I_out   <= 8'sd0;
            Q_out   <= 8'sd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qam16_mapper.sv
// Bench for qam16_mapper: two instances (SYM_DIV=4 and SYM_DIV=1) share random stimulus and
// are compared every cycle against a queue-based reference model plus directed checks.
`timescale 1ns/1ps
module tb_qam16_mapper;

  localparam int DEPTH = 16;
  localparam int AMP   = 32;
  localparam int PLEN  = 4;
  localparam int SD0   = 4;
  localparam int SD1   = 1;
`ifdef QAM16_PREAMBLE_EN
  localparam int PRE_SYMS = PLEN;
`else
  localparam int PRE_SYMS = 0;
`endif

  logic sclk = 1'b0;
  logic rst, enable, data_valid;
  logic [3:0] data_in;
  logic ready_a, sv_a, ur_a, ready_b, sv_b, ur_b;
  logic signed [7:0] i_a, q_a, i_b, q_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int nsym_a = 0;
  int nur_a = 0;
  int log_cyc[$];
  logic [7:0] log_i[$];
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];

  // Reference model state per instance: 0 idle, 1 run, 2 preamble.
  int st[2], kc[2], pc[2], qh[2], qn[2];
  logic [3:0] qm[2][DEPTH];
  logic [7:0] ei[2], eq[2];
  logic esv[2], eur[2];

  always #5 sclk = ~sclk;

  qam16_mapper #(.DEPTH(DEPTH), .SYM_DIV(SD0), .AMP(AMP), .PREAMBLE_LEN(PLEN)) dut_a (
    .sclk(sclk), .rst(rst), .enable(enable), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_a), .I_out(i_a), .Q_out(q_a), .sym_valid(sv_a), .underrun(ur_a));

  qam16_mapper #(.DEPTH(DEPTH), .SYM_DIV(SD1), .AMP(AMP), .PREAMBLE_LEN(PLEN)) dut_b (
    .sclk(sclk), .rst(rst), .enable(enable), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_b), .I_out(i_b), .Q_out(q_b), .sym_valid(sv_b), .underrun(ur_b));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] lvl(input logic [1:0] b);
    int t;
    case (b)
      2'd0:    t = -3;
      2'd1:    t = -1;
      2'd2:    t = 3;
      default: t = 1;
    endcase
    return 8'(t * AMP);
  endfunction

  function automatic void model_edge(input int m, input int sd);
    int pre_n;
    logic [3:0] nib;
    pre_n  = qn[m];
    esv[m] = 1'b0;
    eur[m] = 1'b0;
    if (rst) begin
      st[m] = 0; kc[m] = 0; pc[m] = 0; qh[m] = 0; qn[m] = 0;
      ei[m] = 8'd0; eq[m] = 8'd0;
      return;
    end
    if (!enable) begin
      st[m] = 0; ei[m] = 8'd0; eq[m] = 8'd0;
    end else if (st[m] == 0) begin
      if (pre_n > 0) begin
        st[m] = (PRE_SYMS > 0) ? 2 : 1;
        kc[m] = 0;
        pc[m] = 0;
      end
      ei[m] = 8'd0; eq[m] = 8'd0;
    end else begin
      kc[m]++;
      if (kc[m] % sd == 0) begin
        if (st[m] == 2) begin
          ei[m] = (pc[m] % 2 == 0) ? 8'(3 * AMP) : 8'(-3 * AMP);
          eq[m] = ei[m];
          esv[m] = 1'b1;
          pc[m]++;
          if (pc[m] == PRE_SYMS) st[m] = 1;
        end else if (pre_n > 0) begin
          nib = qm[m][qh[m]];
          ei[m] = lvl(nib[3:2]);
          eq[m] = lvl(nib[1:0]);
          esv[m] = 1'b1;
          qh[m] = (qh[m] + 1) % DEPTH;
          qn[m]--;
        end else begin
          eur[m] = 1'b1; ei[m] = 8'd0; eq[m] = 8'd0; st[m] = 0;
        end
      end
    end
    if (data_valid && pre_n < DEPTH) begin
      qm[m][(qh[m] + qn[m]) % DEPTH] = data_in;
      qn[m]++;
    end
  endfunction

  task automatic step();
    @(posedge sclk);
    model_edge(0, SD0);
    model_edge(1, SD1);
    #1;
    cyc++;
    check_val("a_I",     {24'd0, i_a},     {24'd0, ei[0]});
    check_val("a_Q",     {24'd0, q_a},     {24'd0, eq[0]});
    check_val("a_valid", {31'd0, sv_a},    {31'd0, esv[0]});
    check_val("a_under", {31'd0, ur_a},    {31'd0, eur[0]});
    check_val("a_ready", {31'd0, ready_a}, {31'd0, (qn[0] < DEPTH)});
    check_val("b_I",     {24'd0, i_b},     {24'd0, ei[1]});
    check_val("b_Q",     {24'd0, q_b},     {24'd0, eq[1]});
    check_val("b_valid", {31'd0, sv_b},    {31'd0, esv[1]});
    check_val("b_under", {31'd0, ur_b},    {31'd0, eur[1]});
    check_val("b_ready", {31'd0, ready_b}, {31'd0, (qn[1] < DEPTH)});
    if (sv_a) begin
      nsym_a++;
      log_cyc.push_back(cyc);
      log_i.push_back(i_a);
      log_q.push_back(q_a);
    end
    if (ur_a) nur_a++;
  endtask

  task automatic push_nibble(input logic [3:0] v);
    data_valid = 1'b1;
    data_in    = v;
    step();
    data_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] t2_vals[4];
    t2_vals = '{4'h0, 4'h5, 4'hF, 4'hA};
    rst = 1'b1; enable = 1'b0; data_valid = 1'b0; data_in = 4'h0;
    step(); step();
    rst = 1'b0;
    step();

    // Directed sequence 0x0,0x5,0xF,0xA pushed while disabled, then transmitted.
    foreach (t2_vals[i]) push_nibble(t2_vals[i]);
    log_cyc.delete(); log_i.delete(); log_q.delete();
    enable = 1'b1;
    repeat (4 * (PRE_SYMS + 4) + 10) step();
    exp_q.delete();
    for (int i = 0; i < PRE_SYMS; i++) exp_q.push_back((i % 2 == 0) ? 8'(3 * AMP) : 8'(-3 * AMP));
    exp_q.push_back(8'(-3 * AMP));
    exp_q.push_back(8'(-AMP));
    exp_q.push_back(8'(AMP));
    exp_q.push_back(8'(3 * AMP));
    check_val("t2_count", log_i.size(), exp_q.size());
    for (int i = 0; i < log_i.size() && i < exp_q.size(); i++) begin
      check_val("t2_I", {24'd0, log_i[i]}, {24'd0, exp_q[i]});
      check_val("t2_Q", {24'd0, log_q[i]}, {24'd0, exp_q[i]});
    end
    for (int i = 1; i < log_cyc.size(); i++) check_val("t2_spacing", log_cyc[i] - log_cyc[i-1], SD0);

    // Fill past full while disabled, then drain: 16 symbols and one underrun.
    enable = 1'b0; step();
    for (int i = 0; i < 17; i++) push_nibble(4'($urandom_range(0, 15)));
    check_val("t3_full_ready", {31'd0, ready_a}, 32'd0);
    nsym_a = 0; nur_a = 0;
    enable = 1'b1;
    repeat (4 * (PRE_SYMS + 16) + 12) step();
    check_val("t3_symbols", nsym_a, 16 + PRE_SYMS);
    check_val("t3_underruns", nur_a, 1);

    // Single nibble: one symbol, underrun, then a later push restarts.
    for (int r = 0; r < 2; r++) begin
      nsym_a = 0; nur_a = 0;
      push_nibble(4'($urandom_range(0, 15)));
      repeat (4 * (PRE_SYMS + 2) + 6) step();
      check_val("t4_symbols", nsym_a, 1 + PRE_SYMS);
      check_val("t4_underruns", nur_a, 1);
    end

    // Reset in the middle of a stream discards the buffered nibbles.
    for (int i = 0; i < 6; i++) push_nibble(4'($urandom_range(0, 15)));
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    nsym_a = 0;
    repeat (30) step();
    check_val("t1_no_stale", nsym_a, 0);

    // Full FIFO drained with continuous writes: sits at the full boundary for SYM_DIV=1.
    enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_nibble(4'($urandom_range(0, 15)));
    enable = 1'b1;
    data_valid = 1'b1;
    for (int i = 0; i < 120; i++) begin
      data_in = 4'($urandom_range(0, 15));
      step();
    end

    // Random traffic with occasional enable drops.
    for (int i = 0; i < 600; i++) begin
      data_valid = ($urandom_range(0, 3) != 0);
      data_in    = 4'($urandom_range(0, 15));
      enable     = (i < 200) ? 1'b1 : ($urandom_range(0, 15) != 0);
      step();
    end
    data_valid = 1'b0;
    enable = 1'b1;
    repeat (4 * (DEPTH + PRE_SYMS) + 10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
